// File: rtl/audio_avg_filter_if.sv
// Codec-side handshake and sample bus for audio_avg_filter.
// master = codec/driver side, slave = filter side.
interface audio_avg_filter_if;
  logic               read_ready;
  logic               write_ready;
  logic signed [23:0] readdata_left;
  logic signed [23:0] readdata_right;
  logic               read;
  logic               write;
  logic signed [23:0] writedata_left;
  logic signed [23:0] writedata_right;

  modport master (
    output read_ready, write_ready, readdata_left, readdata_right,
    input  read, write, writedata_left, writedata_right
  );

  modport slave (
    input  read_ready, write_ready, readdata_left, readdata_right,
    output read, write, writedata_left, writedata_right
  );
endinterface

// File: rtl/audio_avg_filter.sv
// Stereo N-tap moving-average filter between codec ADC and DAC FIFOs (N = 2**N_LOG2).
// Optional AUDIO_AVG_BYPASS_EN adds a bypass port that outputs the raw latched sample.
module audio_avg_filter #(
  parameter int N_LOG2 = 4
) (
  input  logic                CLOCK_50,
  input  logic                reset,
`ifdef AUDIO_AVG_BYPASS_EN
  input  logic                bypass,
`endif
  audio_avg_filter_if.slave   codec
);

  localparam int unsigned N  = 2 ** N_LOG2;
  localparam int          DW = 24;
  localparam int          AW = DW + N_LOG2;
  localparam int          PW = N_LOG2;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    UPDATE,
    WRITE
  } state_t;

  state_t                 state_q;
  logic                   read_q;
  logic signed [DW-1:0]   samp_l_q, samp_r_q;
  logic signed [AW-1:0]   acc_l_q, acc_r_q;
  logic signed [DW-1:0]   hist_l_q [N];
  logic signed [DW-1:0]   hist_r_q [N];
  logic        [PW-1:0]   ptr_q;
  logic signed [DW-1:0]   wd_l_q, wd_r_q;

  logic signed [AW-1:0]   sum_l_d, sum_r_d;
  logic signed [DW-1:0]   wd_l_d, wd_r_d;

  function automatic logic signed [AW-1:0] sext(input logic signed [DW-1:0] x);
    return AW'(x);
  endfunction

  // Running sum replaces the oldest tap; the arithmetic shift floors toward -inf.
  always_comb begin
    sum_l_d = acc_l_q + sext(samp_l_q) - sext(hist_l_q[ptr_q]);
    sum_r_d = acc_r_q + sext(samp_r_q) - sext(hist_r_q[ptr_q]);
    wd_l_d  = DW'(sum_l_d >>> N_LOG2);
    wd_r_d  = DW'(sum_r_d >>> N_LOG2);
`ifdef AUDIO_AVG_BYPASS_EN
    if (bypass) begin
      wd_l_d = samp_l_q;
      wd_r_d = samp_r_q;
    end
`endif
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      read_q   <= 1'b0;
      samp_l_q <= '0;
      samp_r_q <= '0;
      acc_l_q  <= '0;
      acc_r_q  <= '0;
      ptr_q    <= '0;
      wd_l_q   <= '0;
      wd_r_q   <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        hist_l_q[i] <= '0;
        hist_r_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (codec.read_ready && codec.write_ready) begin
            samp_l_q <= codec.readdata_left;
            samp_r_q <= codec.readdata_right;
            read_q   <= 1'b1;
            state_q  <= READ;
          end
        end
        READ: begin
          read_q  <= 1'b0;
          state_q <= UPDATE;
        end
        UPDATE: begin
          acc_l_q         <= sum_l_d;
          acc_r_q         <= sum_r_d;
          hist_l_q[ptr_q] <= samp_l_q;
          hist_r_q[ptr_q] <= samp_r_q;
          ptr_q           <= ptr_q + PW'(1);
          wd_l_q          <= wd_l_d;
          wd_r_q          <= wd_r_d;
          state_q         <= WRITE;
        end
        WRITE: begin
          if (codec.write_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign codec.read            = read_q;
  assign codec.write           = (state_q == WRITE) && codec.write_ready;
  assign codec.writedata_left  = wd_l_q;
  assign codec.writedata_right = wd_r_q;

endmodule

// File: doc/audio_avg_filter.md
AUDIO_AVG_FILTER -- requirements
Module: audio_avg_filter

Interface
REQ-001 Parameter N_LOG2, default 4: log2 of the moving-average tap count N = 2^N_LOG2; legal range 1..8.
REQ-002 CLOCK_50  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 read_ready  input  1  codec ADC FIFO holds a stereo sample.
REQ-005 write_ready  input  1  codec DAC FIFO has room for a stereo sample.
REQ-006 readdata_left, readdata_right  input  24 each  signed two's-complement ADC samples from the codec.
REQ-007 read  output  1  one-cycle pop strobe to the codec ADC FIFO.
REQ-008 write  output  1  one-cycle push strobe to the codec DAC FIFO.
REQ-009 writedata_left, writedata_right  output  24 each  filtered signed samples to the codec.
REQ-010 bypass  input  1  present only when AUDIO_AVG_BYPASS_EN is defined (see Configuration).

Function
REQ-011 Block sits between codec ADC output and codec DAC input; it applies an N-tap moving average independently to each channel.
REQ-012 FSM states: IDLE, READ, UPDATE, WRITE.
REQ-013 IDLE: on an edge where read_ready=1 and write_ready=1, latch readdata_left/right into sample registers and go to READ; otherwise stay.
REQ-014 READ: read=1 for exactly this cycle; next edge goes to UPDATE.
REQ-015 UPDATE: per channel, acc <= acc + x - buf[ptr], buf[ptr] <= x; ptr <= ptr+1 modulo N (wraps from N-1 to 0); writedata <= (acc + x - buf[ptr]) arithmetic-shifted right by N_LOG2; next edge goes to WRITE.
REQ-016 Accumulators are signed, 24+N_LOG2 bits; they never overflow; the shift floors toward minus infinity (-1 >>> 2 = -1).
REQ-017 WRITE: write = write_ready (combinational); leave to IDLE on the edge where write_ready=1; stay in WRITE while write_ready=0, holding writedata stable.
REQ-018 read and write are never asserted in the same cycle; at most one read and one write per sample.
REQ-019 Latency: read high the cycle after detection; write high at the earliest 2 cycles after read; IDLE re-entered the cycle after write.
REQ-020 Start-up: buffer entries are zero until overwritten, so the first N-1 outputs ramp (partial sums divided by N).
REQ-021 read_ready falling after IDLE detection has no effect: the latched sample is used and read still pulses once.

Reset
REQ-022 reset=1 asynchronously forces state=IDLE, read=0, write=0, writedata_left/right=0, both accumulators=0, ptr=0, all N buffer entries of both channels=0, sample registers=0.
REQ-023 Reset asserted mid-transaction (any state) aborts the transaction; no read or write strobe is issued during or after reset for that sample.
REQ-024 After reset deassertion the first output is x/N (floor), as if from power-up.

Configuration
REQ-025 Macro AUDIO_AVG_BYPASS_EN: when defined, the bypass port exists; with bypass=1, UPDATE loads writedata with the raw latched sample (buffer, acc, ptr still updated so toggling bypass is glitch-free); handshake timing unchanged.
REQ-026 When AUDIO_AVG_BYPASS_EN is undefined, there is no bypass port and the filtered value is always output.

Verification
REQ-027 N_LOG2=2, both ready held high, left=400 constant -> writedata_left sequence 100, 200, 300, 400, 400.
REQ-028 N_LOG2=2, four samples of 400 then zeros -> outputs 100, 200, 300, 400, 300, 200, 100, 0 (proves ptr wrap and oldest-sample subtraction).
REQ-029 N_LOG2=2, left=-1 (0xFFFFFF), right=+1 single sample -> writedata_left=0xFFFFFF, writedata_right=0; channels independent.
REQ-030 write_ready low for 5 cycles in WRITE -> write=0, writedata stable, no extra read; write pulses once when write_ready rises, then IDLE.
REQ-031 reset pulsed in UPDATE after 3 samples of 400 -> all outputs 0, no write; next sample 400 gives 100.
REQ-032 AUDIO_AVG_BYPASS_EN defined, bypass=1, sample 1234 -> writedata=1234 at same latency; bypass dropped after 4 samples of 1234 -> next output 1234.
